// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply / restoring divide on magnitudes, with sign fix-up at the end.
module muldiv_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_div,
    input  logic        Sign,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        flush,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] LastCnt = 5'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opa_q, opa_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] abs1, abs2;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_tmp;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_neg;
    logic [31:0] rem_neg;
    logic [31:0] quot_neg;

    assign abs1 = (Sign && in1[31]) ? (~in1 + 32'd1) : in1;
    assign abs2 = (Sign && in2[31]) ? (~in2 + 32'd1) : in2;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: acc = {partial remainder, dividend/quotient}; subtract as add of ~d + 1
    assign div_tmp  = {acc_q[63:32], acc_q[31]};
    assign div_diff = div_tmp + {1'b1, ~opa_q} + 33'd1;
    assign div_next = div_diff[32] ? {div_tmp[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

    assign prod_neg = ~acc_q + 64'd1;
    assign rem_neg  = ~acc_q[63:32] + 32'd1;
    assign quot_neg = ~acc_q[31:0] + 32'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !flush) begin
                    state_d   = StRun;
                    busy_d    = 1'b1;
                    cnt_d     = 5'd0;
                    is_div_d  = is_div;
                    neg_res_d = Sign & (in1[31] ^ in2[31]);
                    neg_rem_d = Sign & in1[31];
                    dz_d      = is_div & (in2 == 32'd0);
                    opa_d     = is_div ? abs2 : abs1;
                    acc_d     = {32'd0, is_div ? abs1 : abs2};
                end else if (!start) begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            StRun: begin
                if (flush) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LastCnt) state_d = StFix;
                end
            end
            StFix: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = neg_rem_q ? rem_neg : acc_q[63:32];
                        // Divide by zero keeps the all-ones quotient regardless of sign
                        lo_d = (neg_res_q && !dz_q) ? quot_neg : acc_q[31:0];
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opa_q     <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected {hi,lo} per launched operation.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_div;
    logic        Sign;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    muldiv_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .is_div  (is_div),
        .Sign    (Sign),
        .in1     (in1),
        .in2     (in2),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input bit d, input bit s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        longint la, lb, q, r;
        if (!d) begin
            ea = s ? {{32{a[31]}}, a} : {32'd0, a};
            eb = s ? {{32{b[31]}}, b} : {32'd0, b};
            return ea * eb;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            q  = la / lb;
            r  = la % lb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic issue(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        is_div = d;
        Sign   = s;
        in1    = a;
        in2    = b;
        start  = 1'b1;
        if (push) sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, counting busy cycles (nb0 already elapsed), then scores hi/lo.
    task automatic collect(input string name, input int nb0);
        int nb = nb0;
        int guard = 0;
        logic [63:0] exp;
        while (done !== 1'b1 && guard < 80) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s timeout: done=%b required 1", name, done);
        end
        vectors++;
        if (nb != 33) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d required 33", name, nb);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hX;
        vectors++;
        if ({hi, lo} !== exp) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h required hi=%h lo=%h",
                     name, hi, lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic run(input string name, input bit d, input bit s,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        issue(d, s, a, b, 1'b1, exp);
        collect(name, 0);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse: got done=%b busy=%b required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            miscompares++;
            $display("FAIL post_reset: got busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
    endtask

    task automatic test_mult;
        run("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run("multu_ff", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
        run("mult_ff", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    endtask

    task automatic test_div;
        run("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run("divu_100_7", 1'b1, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        run("divu_by0", 1'b1, 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        run("div_by0_neg", 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        run("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            bit d, s;
            a = $urandom;
            b = (i == 3) ? 32'd0 : $urandom >> (i * 3);
            d = i[0];
            s = i[1];
            run("random", d, s, a, b, model(d, s, a, b));
        end
    endtask

    task automatic test_flush;
        bit saw_done = 1'b0;
        wr_hi = 1'b1; wr_data = 32'hAAAA_0000;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h0000_5555;
        @(negedge clk);
        wr_lo = 1'b0;
        vectors++;
        if (hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin
            miscompares++;
            $display("FAIL preload: got hi=%h lo=%h required aaaa0000 00005555", hi, lo);
        end
        issue(1'b0, 1'b1, 32'd7, 32'd9, 1'b0, 64'd0);
        wr_hi = 1'b1; wr_data = 32'h1234_5678;
        @(negedge clk);
        wr_hi = 1'b0;
        repeat (7) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'hAAAA_0000 || lo !== 32'h0000_5555) begin
            miscompares++;
            $display("FAIL flush: got busy=%b done=%b hi=%h lo=%h required 0 0 aaaa0000 00005555",
                     busy, done, hi, lo);
        end
        repeat (40) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_done || hi !== 32'hAAAA_0000) begin
            miscompares++;
            $display("FAIL flush_quiet: got saw_done=%b hi=%h required 0 aaaa0000", saw_done, hi);
        end
    endtask

    task automatic test_idle_priority;
        start = 1'b1; flush = 1'b1; is_div = 1'b0; in1 = 32'd3; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_start: got busy=%b required 0", busy);
        end
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h0F0F_0F0F;
        @(negedge clk);
        wr_lo = 1'b0; wr_data = 32'hDEAD_BEEF;
        vectors++;
        if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F) begin
            miscompares++;
            $display("FAIL wr_both: got hi=%h lo=%h required 0f0f0f0f 0f0f0f0f", hi, lo);
        end
        issue(1'b0, 1'b0, 32'd6, 32'd7, 1'b1, 64'd42);
        wr_hi = 1'b0;
        vectors++;
        if (hi !== 32'h0F0F_0F0F || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_vs_start: got hi=%h busy=%b required 0f0f0f0f 1", hi, busy);
        end
        collect("wr_vs_start_op", 0);
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        repeat (4) @(negedge clk);
        start = 1'b1; is_div = 1'b0; Sign = 1'b1; in1 = 32'hFFFF_0000; in2 = 32'd77;
        @(negedge clk);
        start = 1'b0;
        collect("start_ignored", 5);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 64'd0);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h required all 0",
                     busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        collect("b2b_first", 0);
        issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        vectors++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: got done=%b busy=%b required 0 1", done, busy);
        end
        collect("b2b_second", 0);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; is_div = 1'b0; Sign = 1'b0;
        in1 = 32'd0; in2 = 32'd0; flush = 1'b0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0;
        test_reset;
        test_mult;
        test_div;
        test_flush;
        test_idle_priority;
        test_start_ignored;
        test_random;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
